// File: rtl/riscv_multicycle_core_if.sv
// Instruction-fetch bus between the multicycle core (master) and external instruction memory (slave).
interface riscv_multicycle_core_if #(parameter int PC_W = 16);
    logic            ireq;
    logic [PC_W-1:0] iaddr;
    logic            ivalid;
    logic [15:0]     idata;

    modport master (output ireq, output iaddr, input ivalid, input idata);
    modport slave  (input ireq, input iaddr, output ivalid, output idata);
endinterface

// File: rtl/riscv_multicycle_core.sv
// Multicycle i16 core: fetch/exec/writeback FSM with optional iterative multiplier.
// Define RISCV_MUL_EN to build the shift-add multiplier; otherwise opcode 101 is a NOP.
//
// state   | meaning
// S_FETCH | request instruction at pc, latch ir on ivalid
// S_EXEC  | read operands, compute alu result / branch target, load multiplier
// S_MUL   | one shift-add step per cycle, L cycles
// S_WB    | write rd and flags, update pc
module riscv_multicycle_core #(
    parameter int              L        = 16,
    parameter int              PC_W     = 16,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic                    clk,
    input  logic                    reset_n,
    riscv_multicycle_core_if.master fetch,
    output logic [1:0]              flags,
    output logic                    busy,
    output logic [8*L-1:0]          debug_data
);
    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_ADDI = 3'b001;
    localparam logic [2:0] OP_SUB  = 3'b010;
    localparam logic [2:0] OP_AND  = 3'b011;
    localparam logic [2:0] OP_XOR  = 3'b100;
    localparam logic [2:0] OP_MUL  = 3'b101;
    localparam logic [2:0] OP_LUI  = 3'b110;
    localparam logic [2:0] OP_BNZ  = 3'b111;

    typedef enum logic [1:0] {S_FETCH, S_EXEC, S_MUL, S_WB} state_t;
    state_t state, state_nx;

    logic [PC_W-1:0] pc, pc_nx, br_pc;
    logic [15:0]     ir;
    logic [L-1:0]    regs [0:7];
    logic [L-1:0]    result, alu_res, alu_b, opa, opb, wdata;
    logic            carry, alu_c, flag_en, wr_en;
    logic [L:0]      sum, diff;
    logic [2:0]      op, rd, rs1, rs2;

    assign op  = ir[15:13];
    assign rd  = ir[12:10];
    assign rs1 = ir[9:7];
    assign rs2 = ir[2:0];
    // regs[0] is only ever cleared, so R0 reads as zero without a special case
    assign opa = regs[rs1];
    assign opb = regs[rs2];

    assign fetch.iaddr = pc;

`ifdef RISCV_MUL_EN
    localparam int CW = $clog2(L + 1);
    logic [L-1:0]  mcand, mplier, prod;
    logic [CW-1:0] count;

    assign busy = (state == S_MUL);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            mcand  <= '0;
            mplier <= '0;
            prod   <= '0;
            count  <= '0;
        end else if (state == S_EXEC) begin
            mcand  <= opa;
            mplier <= opb;
            prod   <= '0;
            count  <= CW'(L);
        end else if (state == S_MUL) begin
            if (mplier[0]) prod <= prod + mcand;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            count  <= count - CW'(1);
        end
    end
`else
    assign busy = 1'b0;
`endif

    always_comb begin
        alu_b   = (op == OP_ADDI) ? {{(L-7){1'b0}}, ir[6:0]} : opb;
        sum     = {1'b0, opa} + {1'b0, alu_b};
        diff    = {1'b0, opa} - {1'b0, opb};
        alu_res = '0;
        alu_c   = 1'b0;
        case (op)
            OP_ADD, OP_ADDI: {alu_c, alu_res} = sum;
            OP_SUB:          {alu_c, alu_res} = diff;
            OP_AND:          alu_res = opa & opb;
            OP_XOR:          alu_res = opa ^ opb;
            OP_LUI:          alu_res = {{(L-10){1'b0}}, ir[9:0]};
            default:         ;
        endcase
        if (op == OP_BNZ && opa != '0) br_pc = pc + {{(PC_W-7){ir[6]}}, ir[6:0]};
        else                           br_pc = pc + PC_W'(1);
    end

    always_comb begin
        flag_en = (op == OP_ADD) || (op == OP_ADDI) || (op == OP_SUB) ||
                  (op == OP_AND) || (op == OP_XOR);
`ifdef RISCV_MUL_EN
        if (op == OP_MUL) flag_en = 1'b1;
        wdata = (op == OP_MUL) ? prod : result;
`else
        wdata = result;
`endif
        wr_en = flag_en || (op == OP_LUI);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) state <= S_FETCH;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx   = state;
        fetch.ireq = 1'b0;
        case (state)
            S_FETCH: begin
                fetch.ireq = 1'b1;
                if (fetch.ivalid) state_nx = S_EXEC;
            end
`ifdef RISCV_MUL_EN
            S_EXEC:  state_nx = (op == OP_MUL) ? S_MUL : S_WB;
            S_MUL:   if (count == CW'(1)) state_nx = S_WB;
`else
            S_EXEC:  state_nx = S_WB;
            S_MUL:   state_nx = S_WB;
`endif
            S_WB:    state_nx = S_FETCH;
            default: state_nx = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pc     <= RESET_PC;
            pc_nx  <= RESET_PC;
            ir     <= '0;
            result <= '0;
            carry  <= 1'b0;
            flags  <= '0;
            for (int i = 0; i < 8; i++) regs[i] <= '0;
        end else begin
            case (state)
                S_FETCH: if (fetch.ivalid) ir <= fetch.idata;
                S_EXEC: begin
                    result <= alu_res;
                    carry  <= alu_c;
                    pc_nx  <= br_pc;
                end
                S_WB: begin
                    pc <= pc_nx;
                    if (wr_en && rd != 3'd0) regs[rd] <= wdata;
                    if (flag_en) flags <= {carry, (wdata == '0)};
                end
                default: ;
            endcase
        end
    end

    for (genvar i = 0; i < 8; i++) begin : g_dbg
        assign debug_data[i*L +: L] = regs[i];
    end
endmodule

// File: tb/tb_riscv_multicycle_core.sv
// Directed bench for riscv_multicycle_core: instruction-level model plus per-cycle output compare.
module tb_riscv_multicycle_core;
    localparam int L = 16;
`ifdef RISCV_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           reset_n;
    logic [1:0]     flags;
    logic           busy;
    logic [8*L-1:0] debug_data;

    riscv_multicycle_core_if #(.PC_W(16)) fetch_if ();

    riscv_multicycle_core #(.L(L), .PC_W(16), .RESET_PC(16'h0000)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .fetch     (fetch_if.master),
        .flags     (flags),
        .busy      (busy),
        .debug_data(debug_data)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_err    = 0;
    bit          live     = 1'b0;
    bit          exp_busy = 1'b0;
    int          last_cycles;
    longint      m_regs [8];
    logic [15:0] m_pc;
    logic [1:0]  m_flags;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [127:0] model_pack();
        logic [127:0] p = '0;
        for (int i = 0; i < 8; i++) p[i*16 +: 16] = 16'(m_regs[i]);
        return p;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_regs[i] = 0;
        m_pc    = 16'h0000;
        m_flags = 2'b00;
    endtask

    // Architectural effect of one instruction, from the opcode table.
    task automatic model_step(input logic [15:0] ins);
        longint a, b, res;
        bit     c, wr, fl;
        int     rd, off;
        longint nxt;
        a   = m_regs[ins[9:7]];
        b   = m_regs[ins[2:0]];
        rd  = int'(ins[12:10]);
        res = 0; c = 1'b0; wr = 1'b0; fl = 1'b0;
        nxt = longint'(m_pc) + 1;
        case (ins[15:13])
            3'b000: begin res = a + b;              c = (res > 65535); wr = 1; fl = 1; end
            3'b001: begin res = a + ins[6:0];       c = (res > 65535); wr = 1; fl = 1; end
            3'b010: begin res = a - b;              c = (a < b);       wr = 1; fl = 1; end
            3'b011: begin res = a & b;              wr = 1; fl = 1; end
            3'b100: begin res = a ^ b;              wr = 1; fl = 1; end
            3'b101: if (MUL_EN) begin res = a * b;  wr = 1; fl = 1; end
            3'b110: begin res = ins[9:0];           wr = 1; end
            default: begin
                off = ins[6] ? int'(ins[6:0]) - 128 : int'(ins[6:0]);
                if (a != 0) nxt = longint'(m_pc) + off;
            end
        endcase
        res = res & 64'hFFFF;
        if (wr && rd != 0) m_regs[rd] = res;
        if (fl) m_flags = {c, (res == 0)};
        m_pc = 16'(nxt & 64'hFFFF);
    endtask

    // Compare process: every cycle after reset release.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (live) begin
                chk("busy", 128'(busy), 128'(exp_busy));
                if (fetch_if.ireq) begin
                    chk("iaddr", 128'(fetch_if.iaddr), 128'(m_pc));
                    chk("regs", debug_data, model_pack());
                    chk("flags", 128'(flags), 128'(m_flags));
                end
            end
        end
    end

    task automatic wait_fetch();
        int n = 0;
        while (!fetch_if.ireq && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!fetch_if.ireq) chk("fetch_timeout", 128'(fetch_if.ireq), 128'(1));
    endtask

    // Issue one instruction after 'stall' idle fetch cycles; abort_k>0 pulses reset at that cycle.
    task automatic issue(input logic [15:0] ins, input int stall, input int abort_k);
        int k;
        bit is_mul;
        is_mul = MUL_EN && (ins[15:13] == 3'b101);
        wait_fetch();
        for (int i = 0; i < stall; i++) begin
            fetch_if.ivalid = 1'b0;
            @(negedge clk);
        end
        fetch_if.ivalid = 1'b1;
        fetch_if.idata  = ins;
        k = 0;
        forever begin
            @(negedge clk);
            k++;
            if (abort_k > 0 && k == abort_k) begin
                reset_n  = 1'b0;
                live     = 1'b0;
                exp_busy = 1'b0;
                fetch_if.ivalid = 1'b0;
                @(negedge clk);
                reset_n = 1'b1;
                model_reset();
                live = 1'b1;
                last_cycles = k;
                return;
            end
            if (fetch_if.ireq || k >= 200) break;
            // ivalid/idata noise outside S_FETCH must be ignored
            fetch_if.ivalid = 1'($urandom_range(0, 1));
            fetch_if.idata  = 16'($urandom);
            exp_busy = is_mul && (k >= 2) && (k <= L + 1);
        end
        exp_busy        = 1'b0;
        fetch_if.ivalid = 1'b0;
        last_cycles     = k;
        chk("latency", 128'(k), 128'(is_mul ? 3 + L : 3));
        model_step(ins);
    endtask

    function automatic logic [15:0] rr(input logic [2:0] op, rd, rs1, rs2);
        return {op, rd, rs1, 4'b0000, rs2};
    endfunction
    function automatic logic [15:0] ri(input logic [2:0] op, rd, rs1, input logic [6:0] imm);
        return {op, rd, rs1, imm};
    endfunction
    function automatic logic [15:0] lui(input logic [2:0] rd, input logic [9:0] imm);
        return {3'b110, rd, imm};
    endfunction

    function automatic logic [15:0] reg_of(input int i);
        return debug_data[i*16 +: 16];
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [6:0] off;
        reset_n         = 1'b0;
        fetch_if.ivalid = 1'b0;
        fetch_if.idata  = 16'h0000;
        model_reset();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        live    = 1'b1;

        chk("rst_ireq", 128'(fetch_if.ireq), 128'(1));
        chk("rst_iaddr", 128'(fetch_if.iaddr), 128'(0));
        chk("rst_debug", debug_data, 128'(0));
        chk("rst_flags", 128'(flags), 128'(0));

        issue(ri(3'b001, 3'd1, 3'd0, 7'd5), 5, 0);
        chk("stall_r1", 128'(reg_of(1)), 128'(5));
        chk("stall_cycles", 128'(last_cycles), 128'(3));

        issue(lui(3'd2, 10'h3FF), 0, 0);
        issue(rr(3'b000, 3'd3, 3'd2, 3'd2), 0, 0);
        chk("add_r3", 128'(reg_of(3)), 128'(16'h07FE));
        chk("add_flags", 128'(flags), 128'(2'b00));
        issue(rr(3'b010, 3'd4, 3'd0, 3'd0), 0, 0);
        chk("sub_r4", 128'(reg_of(4)), 128'(0));
        chk("sub_flags", 128'(flags), 128'(2'b01));
        issue(rr(3'b010, 3'd6, 3'd0, 3'd1), 0, 0);
        chk("borrow_r6", 128'(reg_of(6)), 128'(16'hFFFB));
        chk("borrow_flags", 128'(flags), 128'(2'b10));
        issue(rr(3'b000, 3'd7, 3'd6, 3'd1), 0, 0);
        chk("carry_r7", 128'(reg_of(7)), 128'(0));
        chk("carry_flags", 128'(flags), 128'(2'b11));
        issue(rr(3'b100, 3'd5, 3'd2, 3'd3), 0, 0);
        chk("xor_r5", 128'(reg_of(5)), 128'(16'h0401));
        issue(rr(3'b011, 3'd5, 3'd2, 3'd3), 0, 0);
        chk("and_r5", 128'(reg_of(5)), 128'(16'h03FE));
        issue(rr(3'b000, 3'd0, 3'd2, 3'd2), 0, 0);
        chk("r0_stays", 128'(reg_of(0)), 128'(0));
        issue(ri(3'b001, 3'd6, 3'd6, 7'h7F), 0, 0);
        chk("addi_c_r6", 128'(reg_of(6)), 128'(16'h007A));
        chk("addi_c_flags", 128'(flags), 128'(2'b10));

        issue(lui(3'd1, 10'd300), 0, 0);
        issue(lui(3'd2, 10'd300), 0, 0);
        issue(rr(3'b101, 3'd3, 3'd1, 3'd2), 0, 0);
        if (MUL_EN) begin
            chk("mul_r3", 128'(reg_of(3)), 128'(16'h5F90));
            chk("mul_flags", 128'(flags), 128'(2'b00));
            chk("mul_cycles", 128'(last_cycles), 128'(19));
        end else begin
            chk("nop_r3", 128'(reg_of(3)), 128'(16'h07FE));
            chk("nop_flags", 128'(flags), 128'(2'b10));
            chk("nop_cycles", 128'(last_cycles), 128'(3));
        end

        issue(lui(3'd1, 10'd3), 0, 0);
        off = 7'(10 - int'(m_pc));
        issue(ri(3'b111, 3'd0, 3'd1, off), 0, 0);
        chk("goto_10", 128'(fetch_if.iaddr), 128'(10));
        issue(ri(3'b111, 3'd0, 3'd1, 7'h7E), 0, 0);
        chk("bnz_taken", 128'(fetch_if.iaddr), 128'(8));
        issue(lui(3'd1, 10'd0), 0, 0);
        issue(ri(3'b001, 3'd0, 3'd0, 7'd0), 0, 0);
        issue(ri(3'b111, 3'd0, 3'd1, 7'h7E), 0, 0);
        chk("bnz_not_taken", 128'(fetch_if.iaddr), 128'(11));
        issue(ri(3'b111, 3'd0, 3'd2, 7'h74), 0, 0);
        chk("bnz_to_ffff", 128'(fetch_if.iaddr), 128'(16'hFFFF));
        issue(ri(3'b111, 3'd0, 3'd0, 7'd5), 0, 0);
        chk("pc_wrap", 128'(fetch_if.iaddr), 128'(0));

        issue(lui(3'd1, 10'd300), 0, 0);
        issue(rr(3'b010, 3'd6, 3'd0, 3'd0), 0, 0);
        if (MUL_EN) begin
            issue(rr(3'b101, 3'd6, 3'd1, 3'd2), 0, 5);
            chk("abort_r6", 128'(reg_of(6)), 128'(0));
            chk("abort_busy", 128'(busy), 128'(0));
            chk("abort_iaddr", 128'(fetch_if.iaddr), 128'(0));
            chk("abort_flags", 128'(flags), 128'(0));
            issue(ri(3'b001, 3'd2, 3'd0, 7'd9), 0, 0);
            chk("post_abort_r2", 128'(reg_of(2)), 128'(9));
        end else begin
            issue(rr(3'b101, 3'd5, 3'd1, 3'd2), 0, 0);
            chk("nop_r5", 128'(reg_of(5)), 128'(16'h03FE));
            chk("nop_flags2", 128'(flags), 128'(2'b01));
        end

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
